// File: rtl/multicycle_controller_if.sv
// Bus between the multicycle controller and its datapath: the opcode from
// the instruction register into the controller, the state code, the illegal
// opcode flag and all datapath selects/enables back out.
// The controller takes the master modport and the datapath (or bench) the slave.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [3:0] state;
  logic       illegal_op;
  logic       IorD;
  logic       ALUSrcA;
  logic       RegDst;
  logic       MemtoReg;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [1:0] ALUOp;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic       MemWrite;
  logic       RegWrite;

  modport master (
    input  op,
    output state, illegal_op,
    output IorD, ALUSrcA, RegDst, MemtoReg,
    output ALUSrcB, PCSrc, ALUOp,
    output IRWrite, PCWrite, Branch, MemWrite, RegWrite
  );

  modport slave (
    output op,
    input  state, illegal_op,
    input  IorD, ALUSrcA, RegDst, MemtoReg,
    input  ALUSrcB, PCSrc, ALUOp,
    input  IRWrite, PCWrite, Branch, MemWrite, RegWrite
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// FETCH, MEMRD and MEMWR each last MEM_LAT+1 cycles; the write enables of
// FETCH/MEMWR fire only on the last of those cycles so each pulses once per
// visit. All outputs except the state code are forced to 0 while reset is high.
// Build option: define MULTICYCLE_JUMP_EN to add the JUMP state (op 02);
// without it op 02 is decoded as an unsupported opcode.
module multicycle_controller #(
  parameter int unsigned MEM_LAT = 32'd0  // extra memory wait cycles, 0..15
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10
`ifdef MULTICYCLE_JUMP_EN
    , S_JUMP  = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OP_J     = 6'h02;
`endif

  localparam logic [3:0] LAT_C = 4'(MEM_LAT);

  typedef struct packed {
    logic       illegal_op;
    logic       iord;
    logic       alu_src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       mem_write;
    logic       reg_write;
  } ctl_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       last_wait_s;
  logic       op_supported_s;
  ctl_t       ctl_s;
  ctl_t       ctl_out_s;

  // Memory-bound states advance only when the wait counter reaches MEM_LAT.
  assign last_wait_s = (cnt_q == LAT_C);

  // Classify the opcode as one the controller can execute.
  always_comb begin
    op_supported_s = 1'b0;
    case (bus.op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: op_supported_s = 1'b1;
`ifdef MULTICYCLE_JUMP_EN
      OP_J:                                    op_supported_s = 1'b1;
`endif
      default:                                 op_supported_s = 1'b0;
    endcase
  end

  // State and wait counter; reset returns to FETCH with a cleared count at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-counter logic; unused codes recover to FETCH.
  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    case (state_q)
      S_FETCH: begin
        if (last_wait_s) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:          state_d = S_JUMP;
`endif
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (bus.op)
          OP_LW:   state_d = S_MEMRD;
          OP_SW:   state_d = S_MEMWR;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        if (last_wait_s) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_MEMWR: begin
        if (last_wait_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB:   state_d = S_FETCH;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIWB:  state_d = S_FETCH;
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP:    state_d = S_FETCH;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode; every field not named for a state stays 0.
  always_comb begin
    ctl_s = '0;
    case (state_q)
      S_FETCH: begin
        ctl_s.alu_src_b = 2'b01;
        ctl_s.ir_write  = last_wait_s;
        ctl_s.pc_write  = last_wait_s;
      end
      S_DECODE: begin
        ctl_s.alu_src_b  = 2'b11;
        ctl_s.illegal_op = ~op_supported_s;
      end
      S_MEMADR, S_ADDIEX: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctl_s.iord = 1'b1;
      end
      S_MEMWR: begin
        ctl_s.iord      = 1'b1;
        ctl_s.mem_write = last_wait_s;
      end
      S_MEMWB: begin
        ctl_s.mem_to_reg = 1'b1;
        ctl_s.reg_write  = 1'b1;
      end
      S_ALUWB: begin
        ctl_s.reg_dst   = 1'b1;
        ctl_s.reg_write = 1'b1;
      end
      S_ADDIWB: begin
        ctl_s.reg_write = 1'b1;
      end
      S_EXECUTE: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_op    = 2'b10;
      end
      S_BRANCH: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_op    = 2'b01;
        ctl_s.pc_src    = 2'b01;
        ctl_s.branch    = 1'b1;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        ctl_s.pc_src   = 2'b10;
        ctl_s.pc_write = 1'b1;
      end
`endif
      default: ctl_s = '0;
    endcase
  end

  // Hold every datapath control low for as long as reset is asserted.
  always_comb begin
    if (reset) begin
      ctl_out_s = '0;
    end else begin
      ctl_out_s = ctl_s;
    end
  end

  assign bus.state      = state_q;
  assign bus.illegal_op = ctl_out_s.illegal_op;
  assign bus.IorD       = ctl_out_s.iord;
  assign bus.ALUSrcA    = ctl_out_s.alu_src_a;
  assign bus.RegDst     = ctl_out_s.reg_dst;
  assign bus.MemtoReg   = ctl_out_s.mem_to_reg;
  assign bus.ALUSrcB    = ctl_out_s.alu_src_b;
  assign bus.PCSrc      = ctl_out_s.pc_src;
  assign bus.ALUOp      = ctl_out_s.alu_op;
  assign bus.IRWrite    = ctl_out_s.ir_write;
  assign bus.PCWrite    = ctl_out_s.pc_write;
  assign bus.Branch     = ctl_out_s.branch;
  assign bus.MemWrite   = ctl_out_s.mem_write;
  assign bus.RegWrite   = ctl_out_s.reg_write;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: three instances with MEM_LAT of
// 0, 2 and 3, each exercised in turn. Every cycle the full output vector
// {state, illegal_op, IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, ALUOp,
//  IRWrite, PCWrite, Branch, MemWrite, RegWrite} is compared with a
// hand-written constant for the expected state.
module tb_multicycle_controller;

  logic clk;
  logic rst0;
  logic rst2;
  logic rst3;
  int   n_checks;
  int   n_fail;

  multicycle_controller_if if0 ();
  multicycle_controller_if if2 ();
  multicycle_controller_if if3 ();

  multicycle_controller #(.MEM_LAT(0)) u_lat0 (.clk(clk), .reset(rst0), .bus(if0.master));
  multicycle_controller #(.MEM_LAT(2)) u_lat2 (.clk(clk), .reset(rst2), .bus(if2.master));
  multicycle_controller #(.MEM_LAT(3)) u_lat3 (.clk(clk), .reset(rst3), .bus(if3.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] obs0;
  logic [19:0] obs2;
  logic [19:0] obs3;

  assign obs0 = {if0.state, if0.illegal_op, if0.IorD, if0.ALUSrcA, if0.RegDst, if0.MemtoReg,
                 if0.ALUSrcB, if0.PCSrc, if0.ALUOp, if0.IRWrite, if0.PCWrite, if0.Branch,
                 if0.MemWrite, if0.RegWrite};
  assign obs2 = {if2.state, if2.illegal_op, if2.IorD, if2.ALUSrcA, if2.RegDst, if2.MemtoReg,
                 if2.ALUSrcB, if2.PCSrc, if2.ALUOp, if2.IRWrite, if2.PCWrite, if2.Branch,
                 if2.MemWrite, if2.RegWrite};
  assign obs3 = {if3.state, if3.illegal_op, if3.IorD, if3.ALUSrcA, if3.RegDst, if3.MemtoReg,
                 if3.ALUSrcB, if3.PCSrc, if3.ALUOp, if3.IRWrite, if3.PCWrite, if3.Branch,
                 if3.MemWrite, if3.RegWrite};

  // Pack one expected output vector.
  function automatic logic [19:0] mk(
    input logic [3:0] st, input logic ill, input logic iord, input logic srca,
    input logic rdst, input logic m2r, input logic [1:0] srcb, input logic [1:0] pcs,
    input logic [1:0] aop, input logic irw, input logic pcw, input logic br,
    input logic mw, input logic rw);
    return {st, ill, iord, srca, rdst, m2r, srcb, pcs, aop, irw, pcw, br, mw, rw};
  endfunction

  //                                    st     ill   iord  srcA  rdst  m2r   srcB   pcsrc  aluop  irw   pcw   br    mw    rw
  localparam logic [19:0] V_ZERO    = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [19:0] V_FETCH_W = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [19:0] V_FETCH_L = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  localparam logic [19:0] V_DECODE  = mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [19:0] V_DEC_ILL = mk(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [19:0] V_MEMADR  = mk(4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [19:0] V_MEMRD   = mk(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [19:0] V_MEMWB   = mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  localparam logic [19:0] V_MEMWR_W = mk(4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [19:0] V_MEMWR_L = mk(4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  localparam logic [19:0] V_EXECUTE = mk(4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [19:0] V_ALUWB   = mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  localparam logic [19:0] V_BRANCH  = mk(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  localparam logic [19:0] V_ADDIEX  = mk(4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [19:0] V_ADDIWB  = mk(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [19:0] V_JUMP    = mk(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

  // One comparison: count it, and on mismatch count and report it.
  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next falling edge, then compare one instance.
  task automatic step(input int which, input string tag, input logic [19:0] exp);
    @(negedge clk);
    #1;
    case (which)
      0:       chk(tag, obs0, exp);
      2:       chk(tag, obs2, exp);
      default: chk(tag, obs3, exp);
    endcase
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst0 = 1'b1;
    rst2 = 1'b1;
    rst3 = 1'b1;
    if0.op = 6'h00;
    if2.op = 6'h2B;
    if3.op = 6'h23;

    // Reset state: state 0, every output 0.
    #2;
    chk("reset_lat0", obs0, V_ZERO);
    chk("reset_lat2", obs2, V_ZERO);
    chk("reset_lat3", obs3, V_ZERO);

    // MEM_LAT=0, R-type: 0,1,6,7,0.
    @(negedge clk);
    rst0 = 1'b0;
    #1;
    chk("l0_fetch_first", obs0, V_FETCH_L);
    step(0, "l0_r_decode",  V_DECODE);
    step(0, "l0_r_execute", V_EXECUTE);
    step(0, "l0_r_aluwb",   V_ALUWB);
    step(0, "l0_r_fetch",   V_FETCH_L);

    // MEM_LAT=0, LW: 0,1,2,3,4,0.
    if0.op = 6'h23;
    step(0, "l0_lw_decode", V_DECODE);
    step(0, "l0_lw_memadr", V_MEMADR);
    step(0, "l0_lw_memrd",  V_MEMRD);
    step(0, "l0_lw_memwb",  V_MEMWB);
    step(0, "l0_lw_fetch",  V_FETCH_L);

    // Unsupported op 3F: illegal for one DECODE cycle, straight back to FETCH.
    if0.op = 6'h3F;
    step(0, "l0_ill_decode", V_DEC_ILL);
    step(0, "l0_ill_fetch",  V_FETCH_L);

    // BEQ: 0,1,8,0.
    if0.op = 6'h04;
    step(0, "l0_beq_decode", V_DECODE);
    step(0, "l0_beq_branch", V_BRANCH);
    step(0, "l0_beq_fetch",  V_FETCH_L);

    // ADDI: 0,1,9,10,0.
    if0.op = 6'h08;
    step(0, "l0_addi_decode", V_DECODE);
    step(0, "l0_addi_ex",     V_ADDIEX);
    step(0, "l0_addi_wb",     V_ADDIWB);
    step(0, "l0_addi_fetch",  V_FETCH_L);

    // Op 02: jump when built in, otherwise the illegal path.
    if0.op = 6'h02;
`ifdef MULTICYCLE_JUMP_EN
    step(0, "l0_j_decode", V_DECODE);
    step(0, "l0_j_jump",   V_JUMP);
    step(0, "l0_j_fetch",  V_FETCH_L);
`else
    step(0, "l0_j_decode_ill", V_DEC_ILL);
    step(0, "l0_j_fetch",      V_FETCH_L);
`endif

    // SW with no wait: MEMWR lasts one cycle with MemWrite set.
    if0.op = 6'h2B;
    step(0, "l0_sw_decode", V_DECODE);
    step(0, "l0_sw_memadr", V_MEMADR);
    step(0, "l0_sw_memwr",  V_MEMWR_L);
    step(0, "l0_sw_fetch",  V_FETCH_L);

    // MEM_LAT=2, SW: FETCH x3 (enables on 3rd), DECODE, MEMADR, MEMWR x3 (MemWrite on 3rd).
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    chk("l2_fetch_c0", obs2, V_FETCH_W);
    step(2, "l2_fetch_c1",  V_FETCH_W);
    step(2, "l2_fetch_c2",  V_FETCH_L);
    step(2, "l2_decode",    V_DECODE);
    step(2, "l2_memadr",    V_MEMADR);
    step(2, "l2_memwr_c0",  V_MEMWR_W);
    step(2, "l2_memwr_c1",  V_MEMWR_W);
    step(2, "l2_memwr_c2",  V_MEMWR_L);
    step(2, "l2_next_fetch", V_FETCH_W);

    // MEM_LAT=3, LW: reset raised between edges in the middle of MEMRD.
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    chk("l3_fetch_c0", obs3, V_FETCH_W);
    step(3, "l3_fetch_c1", V_FETCH_W);
    step(3, "l3_fetch_c2", V_FETCH_W);
    step(3, "l3_fetch_c3", V_FETCH_L);
    step(3, "l3_decode",   V_DECODE);
    step(3, "l3_memadr",   V_MEMADR);
    step(3, "l3_memrd_c0", V_MEMRD);
    step(3, "l3_memrd_c1", V_MEMRD);
    #2;
    rst3 = 1'b1;
    #1;
    chk("l3_async_reset", obs3, V_ZERO);
    step(3, "l3_reset_held", V_ZERO);

    // After release, FETCH lasts exactly MEM_LAT+1 = 4 cycles.
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    chk("l3_rel_fetch_c0", obs3, V_FETCH_W);
    step(3, "l3_rel_fetch_c1", V_FETCH_W);
    step(3, "l3_rel_fetch_c2", V_FETCH_W);
    step(3, "l3_rel_fetch_c3", V_FETCH_L);
    step(3, "l3_rel_decode",   V_DECODE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
